// File: rtl/contador_4b.sv
// contador_4b: 4-bit synchronous up/down counter with enable and a parallel
// load from four discrete data bits. Priority: reset > load > count > hold.
module contador_4b #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             updown,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             load,
  output logic [WIDTH-1:0] cont
);

  // Unit step kept at full width so the add/sub stays WIDTH bits and
  // wraps naturally modulo 2**WIDTH.
  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] cont_nxt;

  // a is the MSB, d the LSB of the load word.
  assign ld_data = {a, b, c, d};

  // Next-count selection; reset is applied in the register so it wins
  // over everything decided here.
  always_comb begin
    cont_nxt = cont;
    if (load)
      cont_nxt = ld_data;
    else if (enable)
      cont_nxt = updown ? (cont + STEP) : (cont - STEP);
  end

  // Count register with synchronous active-high reset; cont is driven
  // straight from it, so there is no input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (reset)
      cont <= RESET_VALUE;
    else
      cont <= cont_nxt;
  end

endmodule

// File: tb/tb_contador_4b.sv
// Directed bench for contador_4b: reset priority, up/down wrap, hold,
// load tracking/override and reset in the middle of a count.
module tb_contador_4b;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       updown;
  logic       a, b, c, d;
  logic       load;
  logic [3:0] cont;

  int vec_cnt;
  int err_cnt;

  contador_4b #(
    .WIDTH      (4),
    .RESET_VALUE(4'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .updown(updown),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .load  (load),
    .cont  (cont)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs changed 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_abcd(input logic [3:0] v);
    a = v[3];
    b = v[2];
    c = v[1];
    d = v[0];
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    updown = 1'b1;
    load   = 1'b1;
    set_abcd(4'b1111);
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++;
      if (cont !== 4'h0) begin
        err_cnt++;
        $display("FAIL reset edge %0d: cont=%h expected 0", i, cont);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp;
    reset  = 1'b0;
    load   = 1'b0;
    enable = 1'b1;
    updown = 1'b1;
    set_abcd(4'b0000);
    for (int i = 0; i < 18; i++) begin
      exp = 4'((i + 1) % 16);
      tick();
      vec_cnt++;
      if (cont !== exp) begin
        err_cnt++;
        $display("FAIL up_wrap step %0d: cont=%h expected %h", i, cont, exp);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'h1, 4'h0, 4'hF, 4'hE};
    updown = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++;
      if (cont !== exp_seq[i]) begin
        err_cnt++;
        $display("FAIL down_wrap step %0d: cont=%h expected %h", i, cont, exp_seq[i]);
      end
    end
  endtask

  task automatic test_hold();
    enable = 1'b0;
    load   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      updown = ~updown;
      set_abcd(4'(i * 3));
      tick();
      vec_cnt++;
      if (cont !== 4'hE) begin
        err_cnt++;
        $display("FAIL hold step %0d: cont=%h expected e", i, cont);
      end
    end
  endtask

  task automatic test_load();
    // load with enable low
    enable = 1'b0;
    load   = 1'b1;
    set_abcd(4'b1011);
    tick();
    vec_cnt++;
    if (cont !== 4'hB) begin
      err_cnt++;
      $display("FAIL load_first: cont=%h expected b", cont);
    end
    // load held high tracks new data
    set_abcd(4'b0110);
    tick();
    vec_cnt++;
    if (cont !== 4'h6) begin
      err_cnt++;
      $display("FAIL load_track: cont=%h expected 6", cont);
    end
    // load overrides counting
    enable = 1'b1;
    updown = 1'b1;
    set_abcd(4'b0011);
    tick();
    vec_cnt++;
    if (cont !== 4'h3) begin
      err_cnt++;
      $display("FAIL load_over_up: cont=%h expected 3", cont);
    end
    updown = 1'b0;
    tick();
    vec_cnt++;
    if (cont !== 4'h3) begin
      err_cnt++;
      $display("FAIL load_over_down: cont=%h expected 3", cont);
    end
    // data changes with load low have no effect
    load   = 1'b0;
    enable = 1'b0;
    set_abcd(4'b1111);
    tick();
    vec_cnt++;
    if (cont !== 4'h3) begin
      err_cnt++;
      $display("FAIL load_ignored: cont=%h expected 3", cont);
    end
  endtask

  task automatic test_load_count_reset();
    logic [3:0] exp_seq [3];
    exp_seq = '{4'hF, 4'h0, 4'h1};
    load = 1'b1;
    set_abcd(4'b1110);
    tick();
    vec_cnt++;
    if (cont !== 4'hE) begin
      err_cnt++;
      $display("FAIL lc_load: cont=%h expected e", cont);
    end
    load   = 1'b0;
    enable = 1'b1;
    updown = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (cont !== exp_seq[i]) begin
        err_cnt++;
        $display("FAIL lc_count step %0d: cont=%h expected %h", i, cont, exp_seq[i]);
      end
    end
    // reset mid-count while also loading
    reset = 1'b1;
    load  = 1'b1;
    set_abcd(4'b1001);
    tick();
    vec_cnt++;
    if (cont !== 4'h0) begin
      err_cnt++;
      $display("FAIL lc_reset: cont=%h expected 0", cont);
    end
    // counting resumes from zero
    reset = 1'b0;
    load  = 1'b0;
    tick();
    vec_cnt++;
    if (cont !== 4'h1) begin
      err_cnt++;
      $display("FAIL lc_resume: cont=%h expected 1", cont);
    end
  endtask

  task automatic test_back_to_back();
    // direction flips every edge with no bubbles: 1 -> 2 -> 1 -> 2
    logic [3:0] exp_seq [3];
    exp_seq = '{4'h2, 4'h1, 4'h2};
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      updown = (i % 2 == 0);
      tick();
      vec_cnt++;
      if (cont !== exp_seq[i]) begin
        err_cnt++;
        $display("FAIL b2b step %0d: cont=%h expected %h", i, cont, exp_seq[i]);
      end
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset   = 1'b1;
    enable  = 1'b0;
    updown  = 1'b0;
    load    = 1'b0;
    set_abcd(4'b0000);
    #2;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_hold();
    test_load();
    test_load_count_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
